// File: rtl/spi_div_cmd_decoder_if.sv
// Signal bundle between the SPI byte receiver and the divider command decoder.
// The decoder uses the slave modport; the receiver side (or a bench) uses master.
interface spi_div_cmd_decoder_if #(
    parameter int DIV_W = 32
);
    logic             spi_cs;
    logic [7:0]       rx_byte;
    logic             rx_bit_msb;
    logic [DIV_W-1:0] div_value;
    logic             div_update;
    logic             out_en;
    logic             frame_err;

    modport slave (
        input  spi_cs, rx_byte, rx_bit_msb,
        output div_value, div_update, out_en, frame_err
    );

    modport master (
        output spi_cs, rx_byte, rx_bit_msb,
        input  div_value, div_update, out_en, frame_err
    );
endinterface

// File: rtl/spi_div_cmd_decoder.sv
// Frames bytes from the SPI receiver into divider/enable commands on clk_i.
// state | meaning
// IDLE  | waiting for chip-select to fall
// CMD   | expecting the command byte
// DATA  | collecting payload bytes for DIV or CTRL
// SKIP  | command finished or rejected; ignore bytes until chip-select rises
module spi_div_cmd_decoder #(
    parameter int DIV_W       = 32,
    parameter int DIV_RESET   = 2,
    parameter int SYNC_STAGES = 2
) (
    input logic                clk_i,
    input logic                rst_n,
    spi_div_cmd_decoder_if.slave bus
);
    localparam int NB    = DIV_W / 8;
    localparam int CNT_W = $clog2(NB) + 1;
    localparam int LAST  = SYNC_STAGES - 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA, SKIP} state_t;

    logic [SYNC_STAGES-1:0] cs_s_q;
    logic [SYNC_STAGES-1:0] msb_s_q;
    logic                   msb_prev_q;
    logic                   cs_prev_q;
    state_t                 state_q;
    logic                   tgt_div_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DIV_W-1:0]       acc_q;
    logic [DIV_W-1:0]       div_value_q;
    logic                   div_update_q;
    logic                   out_en_q;
    logic                   frame_err_q;

    logic                   byte_stb;
    logic                   cs_fall;
    logic                   cs_rise;
    logic [DIV_W-1:0]       acc_next;

    // Both CS taps must be low so a counter reset from a CS rise is never taken as a byte.
    assign byte_stb = msb_prev_q & ~msb_s_q[LAST] & ~cs_s_q[0] & ~cs_s_q[LAST];
    assign cs_fall  = cs_prev_q & ~cs_s_q[LAST];
    assign cs_rise  = ~cs_prev_q & cs_s_q[LAST];
    assign acc_next = (acc_q << 8) | DIV_W'(bus.rx_byte);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cs_s_q       <= '1;
            msb_s_q      <= '0;
            msb_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b1;
            state_q      <= IDLE;
            tgt_div_q    <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            div_value_q  <= DIV_W'(DIV_RESET);
            div_update_q <= 1'b0;
            out_en_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cs_s_q       <= {cs_s_q[SYNC_STAGES-2:0], bus.spi_cs};
            msb_s_q      <= {msb_s_q[SYNC_STAGES-2:0], bus.rx_bit_msb};
            msb_prev_q   <= msb_s_q[LAST];
            cs_prev_q    <= cs_s_q[LAST];
            div_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) state_q <= CMD;
                end
                CMD: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                    end else if (byte_stb) begin
                        cnt_q <= '0;
                        if (bus.rx_byte == 8'h01) begin
                            state_q   <= DATA;
                            tgt_div_q <= 1'b1;
                        end else if (bus.rx_byte == 8'h02) begin
                            state_q   <= DATA;
                            tgt_div_q <= 1'b0;
                        end else begin
                            state_q     <= SKIP;
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        state_q     <= IDLE;
                        frame_err_q <= 1'b1;
                    end else if (byte_stb) begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (!tgt_div_q) begin
                            out_en_q <= bus.rx_byte[0];
                            state_q  <= SKIP;
                        end else if (cnt_q == CNT_W'(NB - 1)) begin
                            state_q <= SKIP;
                            // A zero divider is rejected rather than committed.
                            if (acc_next != '0) begin
                                div_value_q  <= acc_next;
                                div_update_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end
                    end
                end
                SKIP: begin
                    if (cs_rise) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.div_value  = div_value_q;
    assign bus.div_update = div_update_q;
    assign bus.out_en     = out_en_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_spi_div_cmd_decoder.sv
// Scoreboard bench: a frame-level model predicts update/error events; a monitor pops and compares them.
module tb_spi_div_cmd_decoder;
    localparam int DIV_W = 32;
    localparam int NB    = DIV_W / 8;

    typedef struct {
        logic [1:0]       kind;   // {div_update, frame_err}
        logic [DIV_W-1:0] div;
        logic             en;
    } evt_t;

    logic clk;
    logic rst_n;
    logic [2:0] bitcnt;
    int n_pass, n_total;

    logic [DIV_W-1:0] m_div;
    logic             m_en;
    logic [7:0]       fb[$];
    evt_t             sb[$];

    spi_div_cmd_decoder_if #(.DIV_W(DIV_W)) bus ();

    spi_div_cmd_decoder #(.DIV_W(DIV_W), .DIV_RESET(2), .SYNC_STAGES(2)) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        evt_t e;
        if (rst_n && (bus.div_update || bus.frame_err)) begin
            if (sb.size() > 0) e = sb.pop_front();
            else begin
                e.kind = 2'b00;
                e.div  = m_div;
                e.en   = m_en;
            end
            check("evt_kind", {62'd0, bus.div_update, bus.frame_err}, {62'd0, e.kind});
            check("evt_div", 64'(bus.div_value), 64'(e.div));
            check("evt_en", 64'(bus.out_en), 64'(e.en));
        end
    end

    task automatic push(input logic [1:0] kind);
        evt_t e;
        e.kind = kind;
        e.div  = m_div;
        e.en   = m_en;
        sb.push_back(e);
    endtask

    // Frame semantics: command byte, then payload; only whole bytes count.
    task automatic model_frame();
        logic [DIV_W-1:0] v;
        if (fb.size() == 0) return;
        if (fb[0] == 8'h01) begin
            if (fb.size() < 1 + NB) push(2'b01);
            else begin
                v = '0;
                for (int i = 1; i <= NB; i++) v = v * 256 + DIV_W'(fb[i]);
                if (v == 0) push(2'b01);
                else begin
                    m_div = v;
                    push(2'b10);
                end
            end
        end else if (fb[0] == 8'h02) begin
            if (fb.size() < 2) push(2'b01);
            else m_en = fb[1][0];
        end else begin
            push(2'b01);
        end
    endtask

    // Receiver model: SPI_CLK period 20 ns (f_CLK = 2*f_SPI_CLK); byte published at wrap.
    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            #20;
            bitcnt = bitcnt + 3'd1;
            bus.rx_bit_msb = bitcnt[2];
            if (bitcnt == 3'd0) bus.rx_byte = b;
        end
    endtask

    task automatic cs_high();
        bus.spi_cs     = 1'b1;
        bitcnt         = 3'd0;
        bus.rx_bit_msb = 1'b0;
        #40;
    endtask

    task automatic run_frame(input int partial);
        model_frame();
        bus.spi_cs = 1'b0;
        #40;
        foreach (fb[i]) send_bits(fb[i], 8);
        if (partial > 0) send_bits(8'hC3, partial);
        #60;
        cs_high();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
        @(negedge clk);
        check("div_state", 64'(bus.div_value), 64'(m_div));
        check("en_state", 64'(bus.out_en), 64'(m_en));
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        bitcnt = 3'd0;
        bus.spi_cs = 1'b1;
        bus.rx_byte = 8'h00;
        bus.rx_bit_msb = 1'b0;
        m_div = 32'd2;
        m_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_div", 64'(bus.div_value), 64'd2);
        check("rst_en", 64'(bus.out_en), 64'd0);
        check("rst_upd", 64'(bus.div_update), 64'd0);
        check("rst_err", 64'(bus.frame_err), 64'd0);
        rst_n = 1'b1;
        #33;

        fb = '{8'h02, 8'h03};               run_frame(0); drain();
        fb = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h55}; run_frame(0); drain();

        // Reset in the middle of a DIV frame after two data bytes.
        bus.spi_cs = 1'b0;
        #40;
        send_bits(8'h01, 8);
        send_bits(8'h12, 8);
        send_bits(8'h34, 8);
        #60;
        @(negedge clk) rst_n = 1'b0;
        repeat (3) @(negedge clk);
        m_div = 32'd2;
        m_en  = 1'b0;
        check("midrst_div", 64'(bus.div_value), 64'd2);
        check("midrst_en", 64'(bus.out_en), 64'd0);
        rst_n = 1'b1;
        #40;
        cs_high();
        drain();

        fb = '{8'h01, 8'h00, 8'h00, 8'h03, 8'hE8}; run_frame(0); drain();
        check("div_3e8", 64'(bus.div_value), 64'h3E8);
        fb = '{8'h02, 8'h03}; run_frame(0); drain();
        check("en_on", 64'(bus.out_en), 64'd1);
        fb = '{8'h02, 8'hFE}; run_frame(0); drain();
        check("en_off", 64'(bus.out_en), 64'd0);
        fb = '{8'h01, 8'h12, 8'h34};               run_frame(0); drain();
        fb = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00}; run_frame(0); drain();
        fb = '{8'h7F, 8'h01};                      run_frame(0); drain();
        fb = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'hAA, 8'hBB}; run_frame(0); drain();
        check("div_10", 64'(bus.div_value), 64'h10);

        fb.delete(); run_frame(5); drain();
        fb = '{8'h02, 8'h01};                      run_frame(0);
        fb = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00}; run_frame(0); drain();

        for (int f = 0; f < 40; f++) begin
            int sel, len;
            fb.delete();
            sel = int'($urandom_range(0, 4));
            len = int'($urandom_range(0, NB + 2));
            if (sel == 4) len = 0;
            else fb.push_back(sel <= 1 ? 8'h01 : (sel == 2 ? 8'h02 : 8'($urandom)));
            for (int i = 0; i < len && sel != 4; i++)
                fb.push_back($urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom));
            run_frame($urandom_range(0, 1) == 1 ? int'($urandom_range(1, 7)) : 0);
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
